// File: rtl/esc_array_if.sv
// ESC driver bus: motor command inputs and per-channel PWM/status outputs.
interface esc_array_if #(
  parameter int NUM_CH = 4,
  parameter int SPD_W  = 11
);
  logic                    wrt;
  logic                    motors_off;
  logic [NUM_CH*SPD_W-1:0] spd;
  logic [NUM_CH-1:0]       pwm;
  logic                    frame;
  logic                    ramping;

  modport master (
    output wrt, motors_off, spd,
    input  pwm, frame, ramping
  );

  modport slave (
    input  wrt, motors_off, spd,
    output pwm, frame, ramping
  );
endinterface

// File: rtl/esc_array.sv
// Multi-channel ESC driver: latches speed targets, slews the applied speed
// once per PWM frame and emits frame-aligned servo-style pulses.
module esc_array #(
  parameter int NUM_CH    = 4,
  parameter int SPD_W     = 11,
  parameter int PERIOD_W  = 20,
  parameter int MIN_PULSE = 50000,
  parameter int SCALE     = 3,
  parameter int SLEW_STEP = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  esc_array_if.slave   bus
);

  localparam longint MAX_PW = longint'(MIN_PULSE) +
                              longint'(SCALE) * ((longint'(1) << SPD_W) - 1);

  if (MAX_PW >= (longint'(1) << PERIOD_W)) begin : g_bad_range
    $error("esc_array: MIN_PULSE + SCALE*(2^SPD_W-1) must be below 2^PERIOD_W");
  end

  if (SLEW_STEP < 1) begin : g_bad_step
    $error("esc_array: SLEW_STEP must be at least 1");
  end

  // A step larger than the speed range behaves like a full-range step, so
  // saturating it lets the arithmetic stay within SPD_W+1 bits.
  localparam int STEP_SAT = (SLEW_STEP > (1 << SPD_W)) ? (1 << SPD_W) : SLEW_STEP;
  localparam logic [SPD_W:0]      STEP     = STEP_SAT[SPD_W:0];
  localparam logic [PERIOD_W-1:0] PW_MIN   = PERIOD_W'(MIN_PULSE);
  localparam logic [PERIOD_W-1:0] PW_SCALE = PERIOD_W'(SCALE);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] cnt_inc;
  logic                wrap;

  logic [SPD_W-1:0]    target   [NUM_CH];
  logic [SPD_W-1:0]    cur      [NUM_CH];
  logic [SPD_W-1:0]    cur_next [NUM_CH];
  logic [PERIOD_W-1:0] pw       [NUM_CH];

  logic [SPD_W:0]      up_sum;
  logic [SPD_W:0]      dn_dif;
  logic                any_diff;

  // Frame counter position decode: the edge leaving the all-ones count is the boundary.
  always_comb begin
    cnt_inc = cnt + 1'b1;
    wrap    = (cnt == '1);
  end

  // Free-running frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end

  // Target capture; shutdown clears every target regardless of wrt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        target[i] <= '0;
      end
    end else if (bus.motors_off) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        target[i] <= '0;
      end
    end else if (bus.wrt) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        target[i] <= bus.spd[i*SPD_W +: SPD_W];
      end
    end
  end

  // Next applied speed: one clipped slew step toward target, or straight to 0 on shutdown.
  always_comb begin
    up_sum = '0;
    dn_dif = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      up_sum      = {1'b0, cur[i]} + STEP;
      dn_dif      = {1'b0, cur[i]} - STEP;
      cur_next[i] = cur[i];
      if (bus.motors_off) begin
        cur_next[i] = '0;
      end else if (target[i] > cur[i]) begin
        cur_next[i] = (up_sum > {1'b0, target[i]}) ? target[i] : up_sum[SPD_W-1:0];
      end else if (target[i] < cur[i]) begin
        cur_next[i] = ({1'b0, cur[i]} >= (STEP + {1'b0, target[i]})) ?
                      dn_dif[SPD_W-1:0] : target[i];
      end
    end
  end

  // Applied speed and pulse width advance only on the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cur[i] <= '0;
        pw[i]  <= PW_MIN;
      end
    end else if (wrap) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cur[i] <= cur_next[i];
        pw[i]  <= PW_MIN + PW_SCALE * PERIOD_W'(cur_next[i]);
      end
    end
  end

  // PWM: rise at the boundary, fall on the edge where the counter reaches pw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pwm <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wrap) begin
          bus.pwm[i] <= 1'b1;
        end else if (cnt_inc == pw[i]) begin
          bus.pwm[i] <= 1'b0;
        end
      end
    end
  end

  // Any channel still away from its target.
  always_comb begin
    any_diff = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cur[i] != target[i]) begin
        any_diff = 1'b1;
      end
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.frame   <= 1'b0;
      bus.ramping <= 1'b0;
    end else begin
      bus.frame   <= wrap;
      bus.ramping <= any_diff;
    end
  end

endmodule

// File: tb/tb_esc_array.sv
// Self-checking bench for esc_array: cycle-by-cycle comparison against a
// frame-level behavioural model, a vector table and hand-written sequences.
module tb_esc_array;
  localparam int NUM_CH    = 4;
  localparam int SPD_W     = 6;
  localparam int PERIOD_W  = 8;
  localparam int MIN_PULSE = 16;
  localparam int SCALE     = 1;
  localparam int SLEW_STEP = 4;
  localparam int FRAME     = 1 << PERIOD_W;
  localparam int SPD_MAX   = (1 << SPD_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  esc_array_if #(.NUM_CH(NUM_CH), .SPD_W(SPD_W)) bus ();

  esc_array #(
    .NUM_CH   (NUM_CH),
    .SPD_W    (SPD_W),
    .PERIOD_W (PERIOD_W),
    .MIN_PULSE(MIN_PULSE),
    .SCALE    (SCALE),
    .SLEW_STEP(SLEW_STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt;
  bit m_started;
  int m_tgt [NUM_CH];
  int m_cur [NUM_CH];
  int m_pw  [NUM_CH];
  bit m_frame;
  bit m_ramp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_started = 0; m_frame = 0; m_ramp = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_tgt[c] = 0; m_cur[c] = 0; m_pw[c] = MIN_PULSE;
      end
    end else begin
      bit boundary;
      boundary = (m_cnt == FRAME - 1);
      m_ramp = 0;
      for (int c = 0; c < NUM_CH; c++) if (m_cur[c] != m_tgt[c]) m_ramp = 1;
      if (boundary) begin
        m_started = 1;
        for (int c = 0; c < NUM_CH; c++) begin
          if (bus.motors_off) m_cur[c] = 0;
          else if (m_tgt[c] > m_cur[c])
            m_cur[c] = (m_cur[c] + SLEW_STEP < m_tgt[c]) ? m_cur[c] + SLEW_STEP : m_tgt[c];
          else
            m_cur[c] = (m_cur[c] - SLEW_STEP > m_tgt[c]) ? m_cur[c] - SLEW_STEP : m_tgt[c];
          m_pw[c] = MIN_PULSE + SCALE * m_cur[c];
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.motors_off) m_tgt[c] = 0;
        else if (bus.wrt) m_tgt[c] = int'((bus.spd >> (c * SPD_W)) & 24'(SPD_MAX));
      end
      m_frame = boundary;
      m_cnt   = (m_cnt + 1) % FRAME;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [NUM_CH-1:0] ep;
      for (int c = 0; c < NUM_CH; c++) ep[c] = m_started && (m_cnt < m_pw[c]);
      chk("model pwm", bus.pwm, ep);
      chk("model frame", bus.frame, m_frame);
      chk("model ramping", bus.ramping, m_ramp);
    end
  end

  // ---------------- helpers ----------------
  int w [NUM_CH];

  task automatic write4(input int a, input int b, input int c, input int d);
    bus.spd = {SPD_W'(d), SPD_W'(c), SPD_W'(b), SPD_W'(a)};
    bus.wrt = 1'b1;
    @(negedge clk);
    bus.wrt = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (bus.frame !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (bus.frame !== 1'b1) chk("frame wait timeout", bus.frame, 1);
  endtask

  // Measures pulse widths over one full frame; ends on the last cycle of the frame.
  task automatic measure(input int off_at);
    wait_frame();
    for (int c = 0; c < NUM_CH; c++) w[c] = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      if (k == off_at) bus.motors_off = 1'b1;
      for (int c = 0; c < NUM_CH; c++) if (bus.pwm[c]) w[c]++;
    end
  endtask

  task automatic chk_w(input string name, input int e0, input int e1, input int e2, input int e3);
    int e [NUM_CH];
    e = '{e0, e1, e2, e3};
    for (int c = 0; c < NUM_CH; c++) chk($sformatf("%s width ch%0d", name, c), w[c], e[c]);
  endtask

  // Called right after reset release: quiet first frame, then idle 16-clock pulses.
  task automatic post_reset(input string name);
    int hi = 0;
    int fr = 0;
    for (int k = 1; k < FRAME; k++) begin
      @(negedge clk);
      if (bus.pwm != '0) hi++;
      if (bus.frame) fr++;
    end
    chk({name, " pwm quiet before first wrap"}, hi, 0);
    chk({name, " no frame before first wrap"}, fr, 0);
    @(negedge clk);
    chk({name, " first frame pulse"}, bus.frame, 1);
    chk({name, " first pulse start"}, bus.pwm, 4'hF);
    for (int f = 0; f < 3; f++) begin
      measure(-1);
      chk_w({name, " idle"}, 16, 16, 16, 16);
      chk({name, " idle ramping"}, bus.ramping, 0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int spd   [NUM_CH];
    bit off;
    int nfr;
    int exp_w [NUM_CH];
  } vec_t;

  vec_t tbl [4];

  task automatic set_vec(input int idx, input int s0, input int s1, input int s2, input int s3,
                         input bit off, input int nfr,
                         input int e0, input int e1, input int e2, input int e3);
    tbl[idx].spd   = '{s0, s1, s2, s3};
    tbl[idx].off   = off;
    tbl[idx].nfr   = nfr;
    tbl[idx].exp_w = '{e0, e1, e2, e3};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2 [6];
    exp2 = '{20, 24, 28, 32, 36, 36};

    set_vec(0, 10, 63, 1, 0,    1'b0, 2,  24, 24, 17, 16);
    set_vec(1, 10, 63, 1, 0,    1'b0, 14, 26, 79, 17, 16);
    set_vec(2, 0, 0, 63, 5,     1'b0, 3,  16, 67, 29, 21);
    set_vec(3, 33, 33, 33, 33,  1'b1, 1,  16, 16, 16, 16);

    bus.wrt = 1'b0; bus.motors_off = 1'b0; bus.spd = '0;
    repeat (3) @(negedge clk);
    chk("reset pwm", bus.pwm, 0);
    chk("reset frame", bus.frame, 0);
    chk("reset ramping", bus.ramping, 0);
    rst_n = 1'b1;

    // Scenario 1: idle after reset
    post_reset("idle");

    // Table-driven vectors
    for (int t = 0; t < 4; t++) begin
      wait_frame();
      repeat (3) @(negedge clk);
      bus.motors_off = tbl[t].off;
      write4(tbl[t].spd[0], tbl[t].spd[1], tbl[t].spd[2], tbl[t].spd[3]);
      for (int f = 0; f < tbl[t].nfr; f++) measure(-1);
      for (int c = 0; c < NUM_CH; c++)
        chk($sformatf("vec%0d width ch%0d", t, c), w[c], tbl[t].exp_w[c]);
      bus.motors_off = 1'b0;
    end

    // Scenario 2: ramp ch0 to 20
    wait_frame();
    repeat (5) @(negedge clk);
    write4(20, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      measure(-1);
      chk_w($sformatf("ramp up f%0d", k), exp2[k], 16, 16, 16);
      chk($sformatf("ramp up ramping f%0d", k), bus.ramping, (k < 4) ? 1 : 0);
    end

    // Scenario 3: ch1 settles at 63, then falls to 2 with a clipped final step
    wait_frame();
    repeat (5) @(negedge clk);
    write4(20, 63, 0, 0);
    for (int f = 0; f < 16; f++) measure(-1);
    chk_w("ch1 settled", 36, 79, 16, 16);
    wait_frame();
    repeat (5) @(negedge clk);
    write4(20, 2, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      measure(-1);
      chk($sformatf("ramp down f%0d ch1", k), w[1], 16 + ((63 - 4 * k > 2) ? 63 - 4 * k : 2));
    end

    // Scenario 4: motors_off mid-pulse
    wait_frame();
    repeat (5) @(negedge clk);
    write4(40, 40, 40, 40);
    for (int f = 0; f < 10; f++) measure(-1);
    chk_w("all at 40", 56, 56, 56, 56);
    measure(20);
    chk_w("off mid-pulse", 56, 56, 56, 56);
    measure(-1);
    chk_w("off next frame", 16, 16, 16, 16);
    wait_frame();
    repeat (5) @(negedge clk);
    write4(50, 50, 50, 50);
    measure(-1);
    chk_w("wrt while off", 16, 16, 16, 16);
    chk("wrt while off ramping", bus.ramping, 0);
    bus.motors_off = 1'b0;
    measure(-1);
    chk_w("after off release", 16, 16, 16, 16);
    chk("after off release ramping", bus.ramping, 0);

    // Scenario 5: wrt on the boundary edge (now on the frame's last cycle)
    write4(0, 0, 8, 0);
    chk("boundary wrt frame", bus.frame, 1);
    for (int k = 0; k < 3; k++) begin
      measure(-1);
      chk($sformatf("boundary wrt f%0d ch2", k), w[2], 16 + 4 * k);
    end

    // Scenario 6: reset mid-pulse
    wait_frame();
    repeat (5) @(negedge clk);
    write4(24, 0, 8, 0);
    for (int f = 0; f < 6; f++) measure(-1);
    chk_w("pre-reset", 40, 16, 24, 16);
    wait_frame();
    repeat (10) @(negedge clk);
    chk("pwm high before reset", bus.pwm[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset pwm", bus.pwm, 0);
    chk("async reset frame", bus.frame, 0);
    chk("async reset ramping", bus.ramping, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    post_reset("after reset");

    // Randomized traffic checked by the model
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      bus.wrt = ($urandom_range(0, 15) == 0);
      bus.spd = (NUM_CH * SPD_W)'($urandom);
      if ($urandom_range(0, 999) == 0) bus.motors_off = ~bus.motors_off;
    end
    bus.wrt = 1'b0;
    bus.motors_off = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
